mem_access_unit: RTL

Bus initiator that drives the 4 KB, 16-bit-word data memory on behalf of the CPU load/store path. It accepts one request at a time over a valid/ready handshake, sequences the memory's address/databus/write_mode pins, and returns read data or a fault as a one-cycle response. Byte stores are done as read-modify-write, because the memory only writes whole words at address[11:1]. It sits between the execute stage and the memory array and is the only master of the memory bus.

---
 rtl/bu_mem_pkg.sv | 37 +++
 rtl/mem_bus_driver.sv | 53 +++++
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bu_mem_pkg.sv
// Shared types, constants and helpers for the memory access unit.
//   mem_state_e  : sequencing states of the bus initiator
//   SIZE_*       : request size encodings
//   MODULE_HI/LO : address bits that select a memory module
//   byte_merge   : replaces one byte lane of a 16-bit word
package bu_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } mem_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int MODULE_HI = 11;
    localparam int MODULE_LO = 10;

    localparam logic [1:0] INSN_MODULE_DEFAULT = 2'b00;

    // Little-endian lane select: lane 0 is [7:0], lane 1 is [15:8].
    function automatic logic [15:0] byte_merge(input logic [15:0] word,
                                               input logic [7:0]  byte_in,
                                               input logic        lane);
        logic [15:0] merged;
        if (lane) begin
            merged = {byte_in, word[7:0]};
        end else begin
            merged = {word[15:8], byte_in};
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_bus_driver.sv
// Registered driver for the memory pins.
//   clk, rst_n       : clock and synchronous active-low reset
//   load_addr        : update mem_addr with next_addr on this edge
//   next_addr        : address for the coming bus cycle
//   next_write_mode  : write_mode for the coming bus cycle
//   next_wdata       : data to drive during the coming write cycle
//   mem_addr         : memory address_bus (holds between loads)
//   mem_write_mode   : memory write_mode
//   mem_data         : memory databus, driven only while mem_write_mode=1
//   bus_rdata        : current databus value, for read capture
module mem_bus_driver #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              next_write_mode,
    input  logic [DATA_W-1:0] next_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_mode,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] bus_rdata
);

    logic [ADDR_W-1:0] addr_r;
    logic              write_mode_r;
    logic [DATA_W-1:0] wdata_r;

    // Bus pin registers; the address only moves when a new bus cycle starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r       <= {ADDR_W{1'b0}};
            write_mode_r <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
        end else begin
            if (load_addr) begin
                addr_r <= next_addr;
            end
            write_mode_r <= next_write_mode;
            wdata_r      <= next_wdata;
        end
    end

    assign mem_addr       = addr_r;
    assign mem_write_mode = write_mode_r;
    // The enable is the registered write_mode itself, so the bus can never
    // be driven outside a write cycle.
    assign mem_data       = write_mode_r ? wdata_r : {DATA_W{1'bz}};
    assign bus_rdata      = mem_data;

endmodule

// File: rtl/mem_access_unit.sv
// Bus initiator between the load/store path and the 16-bit data memory.
// Accepts one request at a time, sequences reads, writes and byte
// read-modify-writes, and returns a one-cycle response.
//   clk, rst_n               : clock, synchronous active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_write, req_size      : 1=store/0=load, 1=word/0=byte
//   req_addr, req_wdata      : byte address, store data (byte uses [7:0])
//   rsp_valid                : one-cycle response pulse
//   rsp_rdata, rsp_fault     : load data (zero-extended bytes), reject flag
//   mem_addr, mem_data,
//   mem_write_mode           : memory pins
module mem_access_unit
    import bu_mem_pkg::*;
#(
    parameter int         ADDR_W       = 12,
    parameter int         DATA_W       = 16,
    parameter bit         PROTECT_INSN = 1'b1,
    parameter logic [1:0] INSN_MODULE  = INSN_MODULE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_write_mode
);

    mem_state_e        state_r;
    mem_state_e        state_s;
    logic              ready_r;
    logic              rsp_valid_r;
    logic              rsp_fault_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic              lat_write_r;
    logic              lat_size_r;
    logic [ADDR_W-1:0] lat_addr_r;
    logic [7:0]        lat_wbyte_r;

    logic              accept_s;
    logic              fault_s;
    logic              load_addr_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              next_wm_s;
    logic [DATA_W-1:0] next_wdata_s;
    logic [DATA_W-1:0] bus_rdata_s;
    logic [DATA_W-1:0] load_data_s;

    assign accept_s = req_valid && ready_r;
    assign fault_s  = ((req_size == SIZE_WORD) && req_addr[0])
                   || (PROTECT_INSN && req_write
                       && (req_addr[MODULE_HI:MODULE_LO] == INSN_MODULE));

    // Next state and the bus command for the coming cycle.  The driver
    // registers the command, so a state's pins are set on entry to it.
    always_comb begin
        state_s      = state_r;
        load_addr_s  = 1'b0;
        next_addr_s  = lat_addr_r;
        next_wm_s    = 1'b0;
        next_wdata_s = {DATA_W{1'b0}};
        load_data_s  = bus_rdata_s;
        if (lat_size_r == SIZE_WORD) begin
            load_data_s = bus_rdata_s;
        end else if (lat_addr_r[0]) begin
            load_data_s = {{(DATA_W-8){1'b0}}, bus_rdata_s[15:8]};
        end else begin
            load_data_s = {{(DATA_W-8){1'b0}}, bus_rdata_s[7:0]};
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (fault_s) begin
                        state_s = ST_RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_s      = ST_WR;
                        load_addr_s  = 1'b1;
                        next_addr_s  = req_addr;
                        next_wm_s    = 1'b1;
                        next_wdata_s = req_wdata;
                    end else begin
                        state_s     = ST_RD_ADDR;
                        load_addr_s = 1'b1;
                        next_addr_s = req_addr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                state_s = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (lat_write_r) begin
                    // Merge straight from the live bus so the write data is
                    // ready on the same edge the read word is captured.
                    state_s      = ST_WR;
                    next_wm_s    = 1'b1;
                    next_wdata_s = byte_merge(bus_rdata_s, lat_wbyte_r,
                                              lat_addr_r[0]);
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_WR: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake, latched request and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            lat_write_r <= 1'b0;
            lat_size_r  <= SIZE_BYTE;
            lat_addr_r  <= {ADDR_W{1'b0}};
            lat_wbyte_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
            if (accept_s) begin
                lat_write_r <= req_write;
                lat_size_r  <= req_size;
                lat_addr_r  <= req_addr;
                lat_wbyte_r <= req_wdata[7:0];
            end
            // RESP entered straight from IDLE only on a rejected request.
            if ((state_s == ST_RESP) && (state_r == ST_IDLE)) begin
                rsp_fault_r <= 1'b1;
                rsp_rdata_r <= {DATA_W{1'b0}};
            end else if ((state_s == ST_RESP) && (state_r == ST_RD_DATA)) begin
                rsp_fault_r <= 1'b0;
                rsp_rdata_r <= load_data_s;
            end else if (state_s == ST_RESP) begin
                rsp_fault_r <= 1'b0;
            end
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_fault = rsp_fault_r;
    assign rsp_rdata = rsp_rdata_r;

    mem_bus_driver #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_addr       (load_addr_s),
        .next_addr       (next_addr_s),
        .next_write_mode (next_wm_s),
        .next_wdata      (next_wdata_s),
        .mem_addr        (mem_addr),
        .mem_write_mode  (mem_write_mode),
        .mem_data        (mem_data),
        .bus_rdata       (bus_rdata_s)
    );

endmodule
